mux_scan_nx1: RTL and testbench
===============================

Name: mux_scan_nx1

Overview:
- Parametrised N-channel, W-bit registered multiplexer with a valid/ready output handshake.
- Next generation of the team's fixed 16:1 single-bit mux; generalised in channel count and data width.
- Adds an auto-scan mode: an internal FSM/counter walks all channels and emits one tagged sample per channel.
- Sits between a bank of parallel sources (sensors, status buses) and a single serial consumer.

Parameters:
- N, 16, channel count; power of two, N >= 2.
- W, 8, data width per channel in bits.
- SW, $clog2(N), select/channel-index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in  in  N*W  channel data; channel k occupies bits [k*W +: W].
- mode  in  1  0 = direct (sel-driven), 1 = scan.
- sel  in  SW  channel index used in direct mode.
- start  in  1  single-cycle pulse; begins a scan when idle and mode=1.
- out  out  W  registered selected data.
- out_ch  out  SW  channel index of the data in out.
- out_valid  out  1  out/out_ch hold a sample.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- busy  out  1  scan in progress.

Behaviour:
- Reset (rst=1 at clk edge): out=0, out_ch=0, out_valid=0, busy=0, FSM=IDLE, scan counter=0. Applies mid-scan; any pending sample is dropped.
- Load condition: load = !out_valid || out_ready. Output registers update only when load=1.
- While out_valid=1 and out_ready=0, out and out_ch stay stable (no change).
- FSM states: IDLE, SCAN.
- IDLE, mode=0 (direct):
  - Every cycle with load=1, capture in[sel] into out and sel into out_ch; set out_valid=1.
  - Latency is 1 clock from sel/in to out.
- IDLE, mode=1, no start: no new loads. If load=1, out_valid clears to 0.
- IDLE, mode=1, start=1: move to SCAN, set counter=0, busy=1.
  - The first sample (channel 0) loads on the same edge if load=1, otherwise on the first later edge where load=1.
- SCAN:
  - On each edge with load=1, capture in[counter] into out and counter into out_ch; set out_valid=1; increment counter.
  - The edge that loads channel N-1 returns the FSM to IDLE with busy=0; that sample remains valid until accepted.
  - The counter does not wrap into a second pass.
- In SCAN, start, mode and sel are ignored; a mode change takes effect only once IDLE.
- start while busy is ignored (not queued).
- Full scan with out_ready held at 1: exactly N transfers on N consecutive cycles, channels 0..N-1 in ascending order.
- in is sampled at the load edge, not at start.

Optional Feature:
- Macro: MUX_SCAN_MASK_EN.
- Defined:
  - Adds input port chan_mask (N bits); bit k=1 includes channel k in scans.
  - SCAN visits only enabled channels, ascending; the last enabled channel ends the scan.
  - start with chan_mask all zero: busy pulses for exactly one cycle, no sample is produced.
  - chan_mask is sampled once on the start edge and held internally for the rest of the scan.
  - Direct mode ignores chan_mask.
- Undefined: no chan_mask port; all N channels are scanned.

Decomposition:
- Package mux_scan_pkg holds:
  - state typedef (IDLE, SCAN);
  - mode constants MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
- Sub-module mux_nx1: purely combinational, parameters N and W, ports in/sel/out. This is the generalised successor of the existing mux4x1/mux16x1.
- mux_scan_nx1 instantiates mux_nx1 once; its select is sel in direct mode, counter in scan mode.
- Next-enabled-channel search (mask build only) lives in mux_scan_nx1.

Test Plan:
- Direct mode: N=16, W=8, in[k]=8'h10+k, out_ready=1, sel sequence 3, 10, 6, 12 -> one cycle later out = 13, 1A, 16, 1C with out_ch matching and out_valid=1.
- Backpressure: direct mode, sel=5 loaded, then out_ready=0 for 4 cycles while sel changes to 9 -> out stays 15, out_ch stays 5; after out_ready=1, out=19 on the next edge.
- Scan: mode=1, start pulse, out_ready=1 -> 16 consecutive transfers with out_ch 0..15 and out 10..1F; busy falls with the last load; a second start during the scan is ignored.
- Scan with stall: out_ready toggles 1,0,0,1 repeatedly -> no channel skipped or duplicated, order preserved, exactly 16 transfers.
- Reset mid-scan: rst asserted at channel 7 -> next cycle out_valid=0, busy=0, out=0; a new start restarts from channel 0.
- Mask (MUX_SCAN_MASK_EN): chan_mask=16'h8421 -> transfers only channels 0, 5, 10, 15; chan_mask=0 -> busy high for one cycle, no transfers.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and constants for the mux_scan_nx1 slice.
//   state_t     : scan FSM state (IDLE, SCAN)
//   MODE_DIRECT : mode input value selecting sel-driven operation
//   MODE_SCAN   : mode input value selecting auto-scan operation
package mux_scan_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nx1.sv
// mux_nx1: purely combinational N:1 multiplexer of W-bit channels.
// Generalised successor of the fixed mux4x1/mux16x1 blocks.
// Ports:
//   in  [N*W-1:0] : channel data, channel k at bits [k*W +: W]
//   sel [SW-1:0]  : channel index
//   out [W-1:0]   : data of the selected channel
module mux_nx1 #(
  parameter  int N  = 16,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic [N*W-1:0] in,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out
);

  always_comb begin
    out = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) out = in[k*W +: W];
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1: N-channel, W-bit registered multiplexer with an output
// valid/ready handshake and an auto-scan mode that emits one tagged sample
// per channel.
//
// Build option: define MUX_SCAN_MASK_EN to add the chan_mask input; scans
// then visit only the enabled channels (mask captured on the start edge).
//
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous, active-high reset
//   in         : channel data, channel k at bits [k*W +: W]
//   mode       : MODE_DIRECT (sel-driven) or MODE_SCAN
//   sel        : channel index used in direct mode
//   start      : single-cycle pulse starting a scan (idle, scan mode only)
//   chan_mask  : (MUX_SCAN_MASK_EN only) per-channel scan enable
//   out        : registered selected data
//   out_ch     : channel index of the data in out
//   out_valid  : out/out_ch hold a sample
//   out_ready  : consumer accepts the sample
//   busy       : scan in progress
//   dbg_state  : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where out_valid && out_ready.
// The output registers may only be rewritten when they are empty or being
// transferred on that same edge (load = !out_valid || out_ready); while
// out_valid is high and out_ready is low, out and out_ch are held unchanged.
module mux_scan_nx1
  import mux_scan_pkg::*;
#(
  parameter  int N  = 16,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic           start,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0]   chan_mask,
`endif
  output logic [W-1:0]   out,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy,
  output state_t         dbg_state
);

  state_t        state;
  logic          load;
  logic [SW-1:0] mux_sel;
  logic [W-1:0]  mux_out;

  // Channel selection for the current scan step and for a start edge.
  logic [SW-1:0] scan_ch;     // channel loaded on the next SCAN load
  logic          scan_last;   // that channel ends the scan
  logic          scan_empty;  // nothing left to visit (empty-mask scan)
  logic [SW-1:0] start_ch;    // channel loaded on a start edge
  logic          start_last;  // the start channel is also the last one
  logic          start_empty; // start with nothing to visit

  assign load      = !out_valid || out_ready;
  assign dbg_state = state;

`ifdef MUX_SCAN_MASK_EN
  // Remaining channels of the current scan; each load clears its bit.
  logic [N-1:0] mask_q;

  function automatic logic [SW-1:0] lowest_set(input logic [N-1:0] m);
    lowest_set = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (m[k]) lowest_set = SW'(k);
    end
  endfunction

  function automatic logic [N-1:0] onehot(input logic [SW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  always_comb begin
    scan_ch     = lowest_set(mask_q);
    scan_empty  = (mask_q == '0);
    scan_last   = ((mask_q & ~onehot(scan_ch)) == '0);
    start_ch    = lowest_set(chan_mask);
    start_empty = (chan_mask == '0);
    start_last  = ((chan_mask & ~onehot(start_ch)) == '0);
  end
`else
  logic [SW-1:0] cnt;

  assign scan_ch     = cnt;
  assign scan_last   = (cnt == SW'(N - 1));
  assign scan_empty  = 1'b0;
  assign start_ch    = '0;
  assign start_last  = 1'b0;  // N >= 2, so channel 0 never ends a scan
  assign start_empty = 1'b0;
`endif

  // The start edge itself may load the first channel, so the mux already
  // points at it while idle in scan mode.
  always_comb begin
    mux_sel = sel;
    if (state == SCAN)            mux_sel = scan_ch;
    else if (mode == MODE_SCAN)   mux_sel = start_ch;
  end

  mux_nx1 #(.N(N), .W(W)) u_mux (
    .in  (in),
    .sel (mux_sel),
    .out (mux_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef MUX_SCAN_MASK_EN
      mask_q    <= '0;
`else
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mode == MODE_DIRECT) begin
            if (load) begin
              out       <= mux_out;
              out_ch    <= sel;
              out_valid <= 1'b1;
            end
          end else if (start && !start_empty) begin
            state <= SCAN;
            busy  <= 1'b1;
`ifdef MUX_SCAN_MASK_EN
            mask_q <= chan_mask;
`else
            cnt    <= '0;
`endif
            if (load) begin
              out       <= mux_out;
              out_ch    <= start_ch;
              out_valid <= 1'b1;
`ifdef MUX_SCAN_MASK_EN
              mask_q    <= chan_mask & ~onehot(start_ch);
`else
              cnt       <= SW'(1);
`endif
              if (start_last) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            // Scan mode without a usable start: drain, never reload.
            if (start && start_empty) begin
              // Empty scan: a single SCAN cycle gives the one-cycle busy.
              state <= SCAN;
              busy  <= 1'b1;
`ifdef MUX_SCAN_MASK_EN
              mask_q <= '0;
`endif
            end
            if (load) out_valid <= 1'b0;
          end
        end

        SCAN: begin
          if (scan_empty) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (load) begin
            out       <= mux_out;
            out_ch    <= scan_ch;
            out_valid <= 1'b1;
`ifdef MUX_SCAN_MASK_EN
            mask_q    <= mask_q & ~onehot(scan_ch);
`else
            cnt       <= cnt + SW'(1);
`endif
            if (scan_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb_mux_scan_nx1: self-checking bench for mux_scan_nx1 (N=16, W=8).
// Honours MUX_SCAN_MASK_EN the same way as the design.
module tb_mux_scan_nx1;
  import mux_scan_pkg::*;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N*W-1:0] in_vec;
  logic           mode;
  logic [SW-1:0]  sel;
  logic           start;
  logic [W-1:0]   out;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
  state_t         dbg_state;
`ifdef MUX_SCAN_MASK_EN
  logic [N-1:0]   chan_mask;
`endif

  mux_scan_nx1 #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_vec),
    .mode      (mode),
    .sel       (sel),
    .start     (start),
`ifdef MUX_SCAN_MASK_EN
    .chan_mask (chan_mask),
`endif
    .out       (out),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: data of channel ch in a packed input vector.
  function automatic logic [W-1:0] pick(input logic [N*W-1:0] v, input int ch);
    return W'(v >> (ch * W));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in();
    for (int k = 0; k < N; k++) in_vec[k*W +: W] = W'($urandom);
  endtask

  // ---------------- scoreboard ----------------
  // Expected channel order of the monitored scan; data is checked against
  // in_vec, which is held constant while the monitor runs.
  logic [SW-1:0] exp_q[$];
  logic          mon_en = 1'b0;
  int            xfers  = 0;

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      logic [SW-1:0] e;
      chk("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mon_ch", 32'(out_ch), 32'(e));
        chk("mon_data", 32'(out), 32'(pick(in_vec, int'(e))));
      end
      xfers++;
    end
  end

  // Runs a monitored scan with out_ready drawn from pat (or random when
  // use_rand is set) and checks the transfer count.
  task automatic monitored_scan(input int n_exp, input bit use_rand);
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    xfers  = 0;
    mon_en = 1'b1;
    start  = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      out_ready = use_rand ? 1'($urandom_range(0, 1)) : pat[cyc % 4];
      step();
      start = 1'b0;
      if (xfers >= n_exp && !busy) break;
    end
    mon_en    = 1'b0;
    out_ready = 1'b1;
    chk("scan_xfers", 32'(xfers), 32'(n_exp));
    chk("scan_q_empty", 32'(exp_q.size()), 32'd0);
    chk("scan_busy_end", 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int sel_list[4] = '{3, 10, 6, 12};
    logic [W-1:0] held;

    rst = 1'b1; mode = MODE_DIRECT; sel = '0; start = 1'b0;
    out_ready = 1'b1; in_vec = '0;
`ifdef MUX_SCAN_MASK_EN
    chan_mask = '1;
`endif
    step(); step();
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    // Direct mode, fixed pattern in[k] = 0x10 + k.
    for (int k = 0; k < N; k++) in_vec[k*W +: W] = W'(8'h10 + k);
    foreach (sel_list[i]) begin
      sel = SW'(sel_list[i]);
      step();
      chk("dir_out", 32'(out), 32'(8'h10 + sel_list[i]));
      chk("dir_ch", 32'(out_ch), 32'(sel_list[i]));
      chk("dir_valid", 32'(out_valid), 32'd1);
    end

    // Direct mode, random data and select each cycle.
    for (int i = 0; i < 24; i++) begin
      int s;
      rand_in();
      s   = $urandom_range(0, N - 1);
      sel = SW'(s);
      step();
      chk("dirr_out", 32'(out), 32'(pick(in_vec, s)));
      chk("dirr_ch", 32'(out_ch), 32'(s));
    end

    // Backpressure: sample of channel 5 held while ready is low.
    rand_in();
    sel = SW'(5);
    step();
    held = pick(in_vec, 5);
    chk("bp_load", 32'(out), 32'(held));
    out_ready = 1'b0;
    sel = SW'(9);
    for (int i = 0; i < 4; i++) begin
      rand_in();
      step();
      chk("bp_hold_out", 32'(out), 32'(held));
      chk("bp_hold_ch", 32'(out_ch), 32'd5);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_out", 32'(out), 32'(pick(in_vec, 9)));
    chk("bp_release_ch", 32'(out_ch), 32'd9);

    // Scan mode without start drains the output.
    mode = MODE_SCAN;
    step();
    chk("scan_idle_valid", 32'(out_valid), 32'd0);
    chk("scan_idle_busy", 32'(busy), 32'd0);

    // Full scan, ready held high, data changing every cycle (sampled at load).
    for (int k = 0; k < N; k++) begin
      rand_in();
      start = (k == 0 || k == 5);  // the second pulse lands mid-scan
      step();
      start = 1'b0;
      chk("scan_ch", 32'(out_ch), 32'(k));
      chk("scan_data", 32'(out), 32'(pick(in_vec, k)));
      chk("scan_valid", 32'(out_valid), 32'd1);
      chk("scan_busy", 32'(busy), 32'(k < N - 1));
    end
    step();
    chk("scan_after_valid", 32'(out_valid), 32'd0);
    chk("scan_after_busy", 32'(busy), 32'd0);

    // Scan with stall pattern 1,0,0,1 on out_ready.
    rand_in();
    for (int k = 0; k < N; k++) exp_q.push_back(SW'(k));
    monitored_scan(N, 1'b0);

    // Scan with random out_ready.
    rand_in();
    for (int k = 0; k < N; k++) exp_q.push_back(SW'(k));
    monitored_scan(N, 1'b1);

    // Reset in the middle of a scan, then restart from channel 0.
    step();
    rand_in();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("mid_ch7", 32'(out_ch), 32'd7);
    chk("mid_state", 32'(dbg_state), 32'(SCAN));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_ch", 32'(out_ch), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_ch", 32'(out_ch), 32'd0);
    chk("restart_data", 32'(out), 32'(pick(in_vec, 0)));
    chk("restart_busy", 32'(busy), 32'd1);
    repeat (N + 2) step();
    chk("restart_done_busy", 32'(busy), 32'd0);

`ifdef MUX_SCAN_MASK_EN
    // Mask 0x8421: channels 0, 5, 10, 15 only.
    begin
      int chs[4] = '{0, 5, 10, 15};
      rand_in();
      chan_mask = 16'h8421;
      start = 1'b1;
      foreach (chs[i]) begin
        step();
        start = 1'b0;
        chan_mask = '0;  // mask is held internally after the start edge
        chk("mask_ch", 32'(out_ch), 32'(chs[i]));
        chk("mask_data", 32'(out), 32'(pick(in_vec, chs[i])));
        chk("mask_busy", 32'(busy), 32'(i < 3));
      end
      step();
      chk("mask_after_valid", 32'(out_valid), 32'd0);
    end

    // Empty mask: one busy cycle, no sample.
    chan_mask = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("mask0_busy", 32'(busy), 32'd1);
    chk("mask0_valid", 32'(out_valid), 32'd0);
    step();
    chk("mask0_busy_end", 32'(busy), 32'd0);
    chk("mask0_valid_end", 32'(out_valid), 32'd0);

    // Random non-empty masks with random backpressure.
    for (int r = 0; r < 3; r++) begin
      logic [N-1:0] m;
      int cnt_en;
      m = N'($urandom) | N'(1 << $urandom_range(0, N - 1));
      cnt_en = 0;
      for (int k = 0; k < N; k++) begin
        if (m[k]) begin
          exp_q.push_back(SW'(k));
          cnt_en++;
        end
      end
      chan_mask = m;
      rand_in();
      monitored_scan(cnt_en, 1'b1);
      step();
    end
    chan_mask = '1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
